// File: rtl/reg_dump_sequencer.sv
// reg_dump_sequencer
// Walks the register bank through its debug read port and streams every
// register value to the debug UART transmitter, least significant byte first.
module reg_dump_sequencer #(
   parameter int NB_DATA = 32,
   parameter int NB_REG  = 5,
   parameter int N_REGS  = 32,
   parameter int NB_BYTE = 8
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_start,
   output logic               o_br_enable,
   output logic [NB_REG-1:0]  o_br_addr,
   input  logic [NB_DATA-1:0] i_br_data,
   output logic [NB_BYTE-1:0] o_tx_data,
   output logic               o_tx_valid,
   input  logic               i_tx_ready,
   output logic               o_busy,
   output logic               o_done
);

   localparam int N_BYTES = NB_DATA / NB_BYTE;
   localparam int NB_CNT  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
   localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(N_BYTES - 1);
   localparam logic [NB_REG-1:0] LAST_ADDR = NB_REG'(N_REGS - 1);

   typedef enum logic [2:0] {
      IDLE,
      SET_ADDR,
      CAPTURE,
      SEND,
      DONE
   } state_t;

   state_t              state_reg;
   logic [NB_DATA-1:0]  shift_reg;
   logic [NB_DATA-1:0]  shift_next;
   logic [NB_CNT-1:0]   byte_cnt_reg;
   logic                accept;

   // The byte on offer is always the low lane of the shift register. Once all
   // lanes have been shifted out the register is zero, so the output idles at 0.
   assign o_tx_data = shift_reg[NB_BYTE-1:0];
   assign accept    = o_tx_valid && i_tx_ready;

   // Shift-right-by-one-byte: each lane takes the lane above it, top lane zero-filled.
   genvar gi;
   generate
      for (gi = 0; gi < N_BYTES; gi++) begin : g_lane
         if (gi == N_BYTES - 1) begin : g_top
            assign shift_next[gi*NB_BYTE +: NB_BYTE] = '0;
         end else begin : g_mid
            assign shift_next[gi*NB_BYTE +: NB_BYTE] = shift_reg[(gi+1)*NB_BYTE +: NB_BYTE];
         end
      end
   endgenerate

   // Dump sequencer: address walk, capture, byte streaming and completion pulse.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_reg    <= IDLE;
         shift_reg    <= '0;
         byte_cnt_reg <= '0;
         o_br_enable  <= 1'b0;
         o_br_addr    <= '0;
         o_tx_valid   <= 1'b0;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (i_start) begin
                  state_reg   <= SET_ADDR;
                  o_br_addr   <= '0;
                  o_br_enable <= 1'b1;
                  o_busy      <= 1'b1;
               end
            end
            // Address held one full cycle so the bank read settles before capture.
            SET_ADDR: begin
               state_reg <= CAPTURE;
            end
            CAPTURE: begin
               shift_reg    <= i_br_data;
               byte_cnt_reg <= '0;
               o_tx_valid   <= 1'b1;
               state_reg    <= SEND;
            end
            SEND: begin
               if (accept) begin
                  shift_reg <= shift_next;
                  if (byte_cnt_reg == LAST_BYTE) begin
                     o_tx_valid   <= 1'b0;
                     byte_cnt_reg <= '0;
                     if (o_br_addr == LAST_ADDR) begin
                        state_reg   <= DONE;
                        o_done      <= 1'b1;
                        o_br_enable <= 1'b0;
                        o_br_addr   <= '0;
                     end else begin
                        o_br_addr <= o_br_addr + 1'b1;
                        state_reg <= SET_ADDR;
                     end
                  end else begin
                     byte_cnt_reg <= byte_cnt_reg + 1'b1;
                  end
               end
            end
            DONE: begin
               o_busy    <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Testbench for reg_dump_sequencer: a bank model answers the debug read port,
// received bytes are compared with a stream built directly from the bank contents.
module tb_reg_dump_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic        rdy;
   logic        br_en;
   logic [4:0]  br_addr;
   logic [31:0] br_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        busy;
   logic        done;

   logic        start4;
   logic        br_en4;
   logic [4:0]  br_addr4;
   logic [31:0] br_data4;
   logic [7:0]  tx_data4;
   logic        tx_valid4;
   logic        busy4;
   logic        done4;

   logic [31:0] bank [32];
   logic [7:0]  got [$];
   logic [7:0]  exp_q [$];

   int checks = 0;
   int errors = 0;

   int done_cnt;
   int done_cyc;
   int hold_err;
   int busy_err;
   bit poked;

   assign br_data  = bank[br_addr];
   assign br_data4 = bank[br_addr4];

   reg_dump_sequencer dut (
      .i_clock    (clk),
      .i_reset    (rst),
      .i_start    (start),
      .o_br_enable(br_en),
      .o_br_addr  (br_addr),
      .i_br_data  (br_data),
      .o_tx_data  (tx_data),
      .o_tx_valid (tx_valid),
      .i_tx_ready (rdy),
      .o_busy     (busy),
      .o_done     (done)
   );

   reg_dump_sequencer #(.N_REGS(4)) dut4 (
      .i_clock    (clk),
      .i_reset    (rst),
      .i_start    (start4),
      .o_br_enable(br_en4),
      .o_br_addr  (br_addr4),
      .i_br_data  (br_data4),
      .o_tx_data  (tx_data4),
      .o_tx_valid (tx_valid4),
      .i_tx_ready (1'b1),
      .o_busy     (busy4),
      .o_done     (done4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void preload();
      for (int n = 0; n < 32; n++) bank[n] = 32'hA0B0C000 + n;
   endfunction

   // Reference stream: registers in ascending order, each little-endian.
   function automatic void build_exp(input int nregs);
      exp_q.delete();
      for (int n = 0; n < nregs; n++)
         for (int b = 0; b < 4; b++)
            exp_q.push_back(8'((bank[n] >> (8 * b)) & 32'hFF));
   endfunction

   // Runs one dump on the default instance; collects accepted bytes and statistics.
   task automatic run_dump(input bit rnd, input int restart_at, input bit poke7);
      bit         prev_stall;
      logic [7:0] prev_data;
      got.delete();
      done_cnt = 0; done_cyc = -1; hold_err = 0; busy_err = 0; poked = 0;
      prev_stall = 0; prev_data = '0;
      start = 1'b1;
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int c = 1; c <= 4000; c++) begin
         @(posedge clk); #1;
         start = (c == restart_at);
         if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) hold_err++;
         if (done === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (done_cyc < 0 && busy !== 1'b1) busy_err++;
         if (done_cyc > 0 && c == done_cyc + 1 && busy !== 1'b0) busy_err++;
         if (poke7 && !poked && br_addr == 5'd7 && tx_valid) begin
            bank[7] = 32'h12345678;
            poked = 1;
         end
         rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (tx_valid && rdy) got.push_back(tx_data);
         prev_stall = tx_valid && !rdy;
         prev_data  = tx_data;
         if (done_cyc >= 0 && c >= done_cyc + 4) break;
      end
      start = 1'b0;
      rdy = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; start4 = 1'b0; rdy = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({br_en, br_addr, tx_data, tx_valid, busy, done} !== 17'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h want 0", {br_en, br_addr, tx_data, tx_valid, busy, done});
      end
      checks++;
      if ({br_en4, br_addr4, tx_data4, tx_valid4, busy4, done4} !== 17'd0) begin
         errors++;
         $display("FAIL reset_outputs_n4: got %h want 0", {br_en4, br_addr4, tx_data4, tx_valid4, busy4, done4});
      end
      rst = 1'b0;
      @(posedge clk); #1;
      $display("test_reset: outputs checked");
   endtask

   task automatic test_ready_high();
      int bad;
      preload();
      build_exp(32);
      run_dump(1'b0, -1, 1'b0);
      checks++;
      if (got.size() !== 128) begin
         errors++; $display("FAIL ready_high_count: got %0d want 128", got.size());
      end
      bad = -1;
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         if (bad < 0 && got[i] !== exp_q[i]) bad = i;
      checks++;
      if (bad >= 0) begin
         errors++; $display("FAIL ready_high_stream: byte[%0d] got %02h want %02h", bad, got[bad], exp_q[bad]);
      end
      checks++;
      if (got.size() < 8 || {got[0], got[1], got[2], got[3], got[4], got[5], got[6], got[7]} !== 64'h00C0B0A0_01C0B0A0) begin
         errors++; $display("FAIL ready_high_head: got %0d bytes, want head 00C0B0A001C0B0A0", got.size());
      end
      checks++;
      if (got.size() != 128 || {got[124], got[125], got[126], got[127]} !== 32'h1FC0B0A0) begin
         errors++; $display("FAIL ready_high_tail: got %0d bytes, want tail 1FC0B0A0", got.size());
      end
      checks++;
      if (done_cyc !== 193) begin
         errors++; $display("FAIL done_latency: got %0d want 193", done_cyc);
      end
      checks++;
      if (done_cnt !== 1) begin
         errors++; $display("FAIL ready_high_done_count: got %0d want 1", done_cnt);
      end
      checks++;
      if (busy_err !== 0) begin
         errors++; $display("FAIL busy_profile: got %0d bad cycles want 0", busy_err);
      end
      $display("test_ready_high: %0d bytes, done after %0d cycles", got.size(), done_cyc);
   endtask

   task automatic test_random_ready();
      int bad;
      preload();
      build_exp(32);
      run_dump(1'b1, -1, 1'b0);
      checks++;
      if (got.size() !== 128) begin
         errors++; $display("FAIL random_count: got %0d want 128", got.size());
      end
      bad = -1;
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         if (bad < 0 && got[i] !== exp_q[i]) bad = i;
      checks++;
      if (bad >= 0) begin
         errors++; $display("FAIL random_stream: byte[%0d] got %02h want %02h", bad, got[bad], exp_q[bad]);
      end
      checks++;
      if (hold_err !== 0) begin
         errors++; $display("FAIL random_hold: got %0d changes under stall want 0", hold_err);
      end
      checks++;
      if (done_cnt !== 1) begin
         errors++; $display("FAIL random_done_count: got %0d want 1", done_cnt);
      end
      $display("test_random_ready: %0d bytes, done after %0d cycles", got.size(), done_cyc);
   endtask

   task automatic test_restart_ignored();
      int bad;
      preload();
      build_exp(32);
      run_dump(1'b0, 50, 1'b0);
      checks++;
      if (got.size() !== 128) begin
         errors++; $display("FAIL restart_count: got %0d want 128", got.size());
      end
      checks++;
      if (done_cnt !== 1) begin
         errors++; $display("FAIL restart_done_count: got %0d want 1", done_cnt);
      end
      bad = -1;
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         if (bad < 0 && got[i] !== exp_q[i]) bad = i;
      checks++;
      if (bad >= 0) begin
         errors++; $display("FAIL restart_stream: byte[%0d] got %02h want %02h", bad, got[bad], exp_q[bad]);
      end
      $display("test_restart_ignored: %0d bytes, %0d done pulses", got.size(), done_cnt);
   endtask

   task automatic test_mid_reset();
      bit found;
      int bad;
      int idle_bad;
      preload();
      build_exp(32);
      got.delete();
      found = 0;
      start = 1'b1; rdy = 1'b1;
      for (int c = 0; c < 400 && !found; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (tx_valid && got.size() == 22) begin
            found = 1;
            rst = 1'b1;
         end else if (tx_valid && rdy) begin
            got.push_back(tx_data);
         end
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL mid_reset_reach: got %0d bytes want 22 before reset", got.size());
      end
      checks++;
      if (br_addr !== 5'd5 || tx_data !== 8'hB0) begin
         errors++; $display("FAIL mid_reset_point: got addr %0d byte %02h want 5 b0", br_addr, tx_data);
      end
      // Start coincides with reset: reset must win.
      start = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({br_en, br_addr, tx_data, tx_valid, busy, done} !== 17'd0) begin
         errors++; $display("FAIL mid_reset_outputs: got %h want 0", {br_en, br_addr, tx_data, tx_valid, busy, done});
      end
      rst = 1'b0; start = 1'b0;
      idle_bad = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (busy !== 1'b0 || tx_valid !== 1'b0 || br_en !== 1'b0) idle_bad++;
      end
      checks++;
      if (idle_bad !== 0) begin
         errors++; $display("FAIL reset_wins_start: got %0d busy cycles want 0", idle_bad);
      end
      run_dump(1'b0, -1, 1'b0);
      bad = -1;
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         if (bad < 0 && got[i] !== exp_q[i]) bad = i;
      checks++;
      if (got.size() !== 128 || bad >= 0) begin
         errors++; $display("FAIL mid_reset_restart: got %0d bytes first bad %0d want 128 from R0", got.size(), bad);
      end
      $display("test_mid_reset: restart dump gave %0d bytes", got.size());
   endtask

   task automatic test_capture_isolation();
      int bad;
      preload();
      build_exp(32);
      run_dump(1'b0, -1, 1'b1);
      checks++;
      if (poked !== 1'b1) begin
         errors++; $display("FAIL r7_write_applied: got %0d want 1", poked);
      end
      bad = -1;
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         if (bad < 0 && got[i] !== exp_q[i]) bad = i;
      checks++;
      if (got.size() !== 128 || bad >= 0) begin
         errors++; $display("FAIL r7_old_value: got %0d bytes first bad %0d want old R7 stream", got.size(), bad);
      end
      preload();
      $display("test_capture_isolation: %0d bytes", got.size());
   endtask

   task automatic test_nregs4();
      int bad;
      int max_addr;
      int dcnt;
      logic [7:0] g4 [$];
      for (int n = 0; n < 32; n++) bank[n] = $urandom;
      build_exp(4);
      max_addr = 0; dcnt = 0;
      start4 = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(posedge clk); #1;
         start4 = 1'b0;
         if (32'(br_addr4) > max_addr) max_addr = 32'(br_addr4);
         if (done4) dcnt++;
         if (tx_valid4) g4.push_back(tx_data4);
      end
      checks++;
      if (g4.size() !== 16) begin
         errors++; $display("FAIL n4_count: got %0d want 16", g4.size());
      end
      bad = -1;
      for (int i = 0; i < g4.size() && i < exp_q.size(); i++)
         if (bad < 0 && g4[i] !== exp_q[i]) bad = i;
      checks++;
      if (bad >= 0) begin
         errors++; $display("FAIL n4_stream: byte[%0d] got %02h want %02h", bad, g4[bad], exp_q[bad]);
      end
      checks++;
      if (max_addr !== 3) begin
         errors++; $display("FAIL n4_max_addr: got %0d want 3", max_addr);
      end
      checks++;
      if (dcnt !== 1) begin
         errors++; $display("FAIL n4_done: got %0d want 1", dcnt);
      end
      checks++;
      if (br_en4 !== 1'b0 || busy4 !== 1'b0) begin
         errors++; $display("FAIL n4_idle_after: got en %0b busy %0b want 0 0", br_en4, busy4);
      end
      preload();
      $display("test_nregs4: %0d bytes, max addr %0d", g4.size(), max_addr);
   endtask

   initial begin
      preload();
      test_reset();
      test_ready_high();
      test_random_ready();
      test_restart_ignored();
      test_mid_reset();
      test_capture_isolation();
      test_nregs4();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_dump_sequencer.md
Name: reg_dump_sequencer

Overview:
- Debug-side initiator for the decode stage's register-bank debug read port.
- On a start pulse, takes ownership of the debug read address (br_enable/br_addr), walks registers 0..N_REGS-1, and captures each 32-bit value.
- Streams each value as bytes, LSB first, to the debug UART transmitter over a valid/ready byte handshake.
- Sits between the debug unit's command FSM (start/done) and the UART TX byte interface.

Parameters:
- NB_DATA, 32, register data width; must be a multiple of NB_BYTE.
- NB_REG, 5, register address width.
- N_REGS, 32, number of registers dumped; must be ≤ 2^NB_REG.
- NB_BYTE, 8, width of the TX byte interface.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  reset, synchronous, active-high.
- i_start  in  1  one-cycle request to begin a dump; honoured only in IDLE.
- o_br_enable  out  1  high while the sequencer owns the bank debug read address.
- o_br_addr  out  NB_REG  register address presented to the bank debug read port.
- i_br_data  in  NB_DATA  register data returned by the decode stage debug read port.
- o_tx_data  out  NB_BYTE  byte offered to the UART TX.
- o_tx_valid  out  1  o_tx_data is valid.
- i_tx_ready  in  1  TX accepts the byte.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse when the final byte of the final register is accepted.

Behaviour:
- Reset values:
  - o_br_enable=0, o_br_addr=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0.
  - Internal shift register and byte counter cleared; state=IDLE.
- Reset mid-dump aborts immediately with the values above. No partial-word completion; the next dump restarts at register 0.
- All outputs are registered.
- States: IDLE, SET_ADDR, CAPTURE, SEND, DONE.
- IDLE:
  - Outputs at reset values.
  - i_start=1 → SET_ADDR with o_br_addr=0, o_br_enable=1, o_busy=1.
- SET_ADDR:
  - One cycle; o_br_addr is stable, which gives the bank read one full cycle to settle. → CAPTURE.
- CAPTURE:
  - Latch i_br_data into the shift register; byte count=0.
  - Next cycle → SEND with o_tx_valid=1 and o_tx_data=captured[NB_BYTE-1:0].
- SEND:
  - A byte is accepted only in a cycle where o_tx_valid=1 and i_tx_ready=1.
  - While not accepted, o_tx_data and o_tx_valid hold.
  - On accept: shift right by NB_BYTE and increment the byte count.
    - If bytes remain, present the next byte the following cycle with valid kept high (no bubble).
    - After the NB_DATA/NB_BYTE-th accept: o_tx_valid=0.
      - If o_br_addr == N_REGS-1 → DONE.
      - Else o_br_addr+1 → SET_ADDR.
- DONE:
  - One cycle: o_done=1, o_br_enable=0, o_br_addr=0. → IDLE.
- o_br_enable stays high continuously from SET_ADDR of register 0 through the last SEND.
- i_start while busy is ignored; it is not queued.
- i_start in the same cycle as i_reset: reset wins.
- o_br_addr never exceeds N_REGS-1 and never wraps; the counter stops at the last register.
- i_br_data is sampled only in CAPTURE; changes during SEND do not affect the bytes already latched.
- Throughput with i_tx_ready held high: 2 + NB_DATA/NB_BYTE cycles per register. Defaults: 6 cycles per register, 192 cycles from the first SET_ADDR to the last accept, o_done one cycle later.
- Byte order per register is little-endian, LSB first. Registers go out in ascending address order.

Test Plan:
- Bank preloaded with Rn = 0xA0B0C000+n; pulse i_start; i_tx_ready held 1.
  - Required: 128 bytes, beginning 00 C0 B0 A0 01 C0 B0 A0.
  - Last four bytes 1F C0 B0 A0.
  - o_done pulses exactly 193 cycles after i_start; o_busy falls with it.
- Same preload, i_tx_ready toggling 1/0 pseudo-randomly.
  - Required: identical 128-byte stream.
  - o_tx_data never changes while o_tx_valid=1 and i_tx_ready=0.
  - No byte duplicated or dropped.
- i_start pulsed again at cycle 50 of a dump.
  - Required: ignored; exactly 128 bytes and one o_done.
- i_reset asserted while sending byte 2 of R5.
  - Required: next cycle all outputs 0, state IDLE.
  - A new i_start restarts at R0 with byte 00.
- R7 written to 0x12345678 while R7's bytes are being sent, after CAPTURE.
  - Required: the old R7 value is transmitted, not 0x12345678.
- Parameter set N_REGS=4: dump.
  - Required: 16 bytes; o_br_addr peaks at 3; o_done pulses; o_br_enable low afterwards.
